pattern_gen: RTL and testbench
==============================

PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter WIDTH, default 8: width of dout and seed; legal range 2..32.
REQ-002 Parameter DIV, default 4: clock cycles per pattern step; legal range 1..65535.
REQ-003 Parameter TAPS, default 8'hB8: Galois LFSR feedback mask, WIDTH bits wide.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  run enable; when low, the prescaler and pattern hold.
REQ-007 mode  input  2  pattern select: 00 toggle, 01 up-count, 10 down-count, 11 LFSR.
REQ-008 load  input  1  single-cycle seed load strobe.
REQ-009 seed  input  WIDTH  value loaded into dout on load.
REQ-010 dout  output  WIDTH  current pattern value; registered.
REQ-011 step  output  1  registered pulse, high for the one cycle in which dout shows a value just produced by a step.
REQ-012 wrap  output  1  registered pulse, high together with step when that step wrapped (see REQ-020).

Function
REQ-013 Prescaler: internal counter sized ceil(log2(DIV)) bits (min 1); when en=1 it counts 0..DIV-1 and returns to 0; when en=0 it holds.
REQ-014 Step event: en=1 and prescaler=DIV-1; dout updates on that edge, and step=1 in the following cycle; step=0 in all other cycles.
REQ-015 DIV=1: step event every cycle with en=1, so step stays high continuously while en=1.
REQ-016 Toggle mode (00): dout <= ~dout on each step event.
REQ-017 Up mode (01): dout <= dout+1 modulo 2^WIDTH.
REQ-018 Down mode (10): dout <= dout-1 modulo 2^WIDTH.
REQ-019 LFSR mode (11): Galois right shift; if dout[0]=1 then dout <= (dout>>1) ^ TAPS, else dout <= dout>>1; if dout=0 at a step event, dout <= 1 (lock-up escape).
REQ-020 wrap=1 with step when: up mode stepped all-ones->0; down mode stepped 0->all-ones; LFSR mode produced the value 1; toggle mode stepped to all-ones.
REQ-021 mode is sampled only at step events; changing mode between steps has no effect until the next step event; the prescaler is not disturbed.
REQ-022 load=1 (rst=0): dout <= seed, prescaler <= 0, step <= 0, wrap <= 0; load overrides a coincident step event and works regardless of en.
REQ-023 load with seed=0 in LFSR mode loads 0; REQ-019 recovers at the next step.
REQ-024 en deasserted mid-interval: prescaler freezes and resumes from the same count when en returns; no step is lost or duplicated.
REQ-025 Latency: first step after reset or load with en held high occurs DIV cycles later; dout is valid in the same cycle step is high.

Reset
REQ-026 rst=1 at a clock edge: dout=0, prescaler=0, step=0, wrap=0.
REQ-027 rst has priority over load and en; a reset asserted mid-interval discards the partial prescaler count.
REQ-028 After reset deassertion, behaviour is identical to a load of seed=0 in the same cycle.

Verification
REQ-029 WIDTH=8, DIV=4, mode=01, load seed=8'hFE, en=1 -> dout FF after 4 cycles (step=1, wrap=0), then 00 after 4 more cycles (step=1, wrap=1).
REQ-030 mode=10, load 8'h01, DIV=4 -> dout 00 then FF on consecutive steps; wrap=1 on the FF step only.
REQ-031 mode=11, TAPS=8'hB8, load 8'h01 -> 255 consecutive steps produce no repeat, and the 256th value is 01 with wrap=1.
REQ-032 mode=11, rst then en=1 -> first step gives dout=01 (lock-up escape) with wrap=1.
REQ-033 DIV=4, en dropped for 5 cycles after 2 counted cycles -> next step 2 enabled cycles after en returns; load asserted on a step-event cycle -> dout=seed, step=0.
REQ-034 DIV=1, mode=00, load 8'h0F -> dout alternates F0/0F each cycle, step held high, wrap=0; rst mid-run -> dout=00 next cycle.

Source files
------------

// File: rtl/pattern_gen_if.sv
// Control and pattern bundle for pattern_gen.
// The master drives the controls; the slave (the generator) drives the pattern outputs.
interface pattern_gen_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic [1:0]       mode;
   logic             load;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] dout;
   logic             step;
   logic             wrap;

   modport master (
      output en, mode, load, seed,
      input  dout, step, wrap
   );

   modport slave (
      input  en, mode, load, seed,
      output dout, step, wrap
   );
endinterface

// File: rtl/pattern_gen.sv
// Prescaled pattern generator: toggle, up/down count and Galois LFSR.
// A step fires every DIV enabled cycles; step/wrap flag the new dout.
module pattern_gen #(
   parameter int unsigned      WIDTH = 8,
   parameter int unsigned      DIV   = 4,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
   input  logic        clk,
   input  logic        rst,
   pattern_gen_if.slave bus
);
   localparam int unsigned      PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    LAST = PW'(DIV - 1);
   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   localparam logic [1:0] M_TOG  = 2'b00;
   localparam logic [1:0] M_UP   = 2'b01;
   localparam logic [1:0] M_DOWN = 2'b10;
   localparam logic [1:0] M_LFSR = 2'b11;

   logic [PW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;

   logic             evt;
   logic [WIDTH-1:0] pat_n;
   logic             wrap_n;

   assign evt = bus.en && (cnt_q == LAST);

   always_comb begin
      pat_n  = dout_q;
      wrap_n = 1'b0;
      unique case (bus.mode)
         M_TOG: begin
            pat_n  = ~dout_q;
            wrap_n = (dout_q == '0);
         end
         M_UP: begin
            pat_n  = dout_q + 1'b1;
            wrap_n = (dout_q == ONES);
         end
         M_DOWN: begin
            pat_n  = dout_q - 1'b1;
            wrap_n = (dout_q == '0);
         end
         M_LFSR: begin
            // all-zero is the LFSR lock-up state; escape to 1
            if (dout_q == '0)
               pat_n = ONE;
            else if (dout_q[0])
               pat_n = (dout_q >> 1) ^ TAPS;
            else
               pat_n = dout_q >> 1;
            wrap_n = (pat_n == ONE);
         end
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      dout_d = dout_q;
      step_d = 1'b0;
      wrap_d = 1'b0;
      if (bus.load) begin
         cnt_d  = '0;
         dout_d = bus.seed;
      end else if (bus.en) begin
         cnt_d  = evt ? '0 : cnt_q + 1'b1;
         if (evt) begin
            dout_d = pat_n;
            step_d = 1'b1;
            wrap_d = wrap_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         dout_q <= '0;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         step_q <= step_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.dout = dout_q;
   assign bus.step = step_q;
   assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: DUT A (DIV=4) and DUT B (DIV=1).
// Stimulus queues expected steps/probes; one monitor compares them.
module tb_pattern_gen;
   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   pattern_gen_if #(.WIDTH(8)) ifa ();
   pattern_gen_if #(.WIDTH(8)) ifb ();

   pattern_gen #(.WIDTH(8), .DIV(4), .TAPS(8'hB8)) dut_a (
      .clk(clk), .rst(rst_a), .bus(ifa.slave)
   );
   pattern_gen #(.WIDTH(8), .DIV(1), .TAPS(8'hB8)) dut_b (
      .clk(clk), .rst(rst_b), .bus(ifb.slave)
   );

   logic [8:0]  exp_a[$], exp_b[$];
   logic [9:0]  prb_a[$], prb_b[$];
   int          checks = 0;
   int          errors = 0;
   logic        done   = 1'b0;

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(posedge clk) begin
      logic [8:0] e;
      logic [9:0] p;
      #1;
      if (prb_a.size() > 0) begin
         p = prb_a.pop_front();
         checks++;
         if ({ifa.step, ifa.wrap, ifa.dout} !== p) begin
            errors++;
            $display("FAIL probe_a: got step/wrap/dout %b/%b/%h want %b/%b/%h",
                     ifa.step, ifa.wrap, ifa.dout, p[9], p[8], p[7:0]);
         end
      end
      if (ifa.step === 1'b1) begin
         checks++;
         if (exp_a.size() == 0) begin
            errors++;
            $display("FAIL step_a: unexpected step dout=%h", ifa.dout);
         end else begin
            e = exp_a.pop_front();
            if ({ifa.wrap, ifa.dout} !== e) begin
               errors++;
               $display("FAIL step_a: got wrap/dout %b/%h want %b/%h",
                        ifa.wrap, ifa.dout, e[8], e[7:0]);
            end
         end
      end
      if (prb_b.size() > 0) begin
         p = prb_b.pop_front();
         checks++;
         if ({ifb.step, ifb.wrap, ifb.dout} !== p) begin
            errors++;
            $display("FAIL probe_b: got step/wrap/dout %b/%b/%h want %b/%b/%h",
                     ifb.step, ifb.wrap, ifb.dout, p[9], p[8], p[7:0]);
         end
      end
      if (ifb.step === 1'b1) begin
         checks++;
         if (exp_b.size() == 0) begin
            errors++;
            $display("FAIL step_b: unexpected step dout=%h", ifb.dout);
         end else begin
            e = exp_b.pop_front();
            if ({ifb.wrap, ifb.dout} !== e) begin
               errors++;
               $display("FAIL step_b: got wrap/dout %b/%h want %b/%h",
                        ifb.wrap, ifb.dout, e[8], e[7:0]);
            end
         end
      end
      if (done) begin
         checks++;
         if (exp_a.size() + exp_b.size() != 0) begin
            errors++;
            $display("FAIL missed_steps: got %0d/%0d pending want 0/0",
                     exp_a.size(), exp_b.size());
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      logic [7:0] v;
      rst_a = 1'b1; rst_b = 1'b1;
      ifa.en = 1'b0; ifa.mode = 2'b00; ifa.load = 1'b0; ifa.seed = 8'h00;
      ifb.en = 1'b0; ifb.mode = 2'b00; ifb.load = 1'b0; ifb.seed = 8'h00;
      run(2);
      prb_a.push_back(10'h000);
      prb_b.push_back(10'h000);
      run(1);
      rst_a = 1'b0; rst_b = 1'b0;
      run(1);

      // up-count through all-ones -> 0
      ifa.mode = 2'b01; ifa.seed = 8'hFE; ifa.load = 1'b1; ifa.en = 1'b1;
      run(1);
      ifa.load = 1'b0;
      exp_a.push_back({1'b0, 8'hFF});
      exp_a.push_back({1'b1, 8'h00});
      run(8);
      ifa.en = 1'b0;
      run(2);

      // down-count through 0 -> all-ones
      ifa.mode = 2'b10; ifa.seed = 8'h01; ifa.load = 1'b1; ifa.en = 1'b1;
      run(1);
      ifa.load = 1'b0;
      exp_a.push_back({1'b0, 8'h00});
      exp_a.push_back({1'b1, 8'hFF});
      run(8);
      ifa.en = 1'b0;
      run(2);

      // full LFSR period from seed 01
      ifa.mode = 2'b11; ifa.seed = 8'h01; ifa.load = 1'b1; ifa.en = 1'b1;
      run(1);
      ifa.load = 1'b0;
      v = 8'h01;
      for (int i = 0; i < 255; i++) begin
         v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
         exp_a.push_back({v == 8'h01, v});
      end
      run(255 * 4);
      ifa.en = 1'b0;
      run(2);

      // LFSR lock-up escape after reset
      rst_a = 1'b1;
      run(1);
      rst_a = 1'b0; ifa.en = 1'b1;
      exp_a.push_back({1'b1, 8'h01});
      run(4);
      ifa.en = 1'b0;
      run(2);

      // en pause mid-interval, then load on a step-event cycle
      ifa.mode = 2'b01; ifa.seed = 8'h10; ifa.load = 1'b1; ifa.en = 1'b1;
      run(1);
      ifa.load = 1'b0;
      run(2);
      ifa.en = 1'b0;
      run(5);
      ifa.en = 1'b1;
      exp_a.push_back({1'b0, 8'h11});
      run(2);
      run(3);
      ifa.seed = 8'hAA; ifa.load = 1'b1;
      prb_a.push_back({1'b0, 1'b0, 8'hAA});
      run(1);
      ifa.load = 1'b0;
      exp_a.push_back({1'b0, 8'hAB});
      run(4);
      ifa.en = 1'b0;
      run(2);

      // DIV=1 toggle, reset mid-run, then toggle 00 -> FF wraps
      ifb.mode = 2'b00; ifb.seed = 8'h0F; ifb.load = 1'b1; ifb.en = 1'b1;
      run(1);
      ifb.load = 1'b0;
      for (int i = 0; i < 6; i++)
         exp_b.push_back({1'b0, (i % 2 == 0) ? 8'hF0 : 8'h0F});
      run(6);
      rst_b = 1'b1;
      prb_b.push_back(10'h000);
      run(1);
      rst_b = 1'b0;
      exp_b.push_back({1'b1, 8'hFF});
      run(1);
      ifb.en = 1'b0;
      run(2);

      done = 1'b1;
      run(3);
      $display("FAIL monitor_end: summary not reached");
      $fatal(1);
   end
endmodule
